// File: rtl/pix_gray_bin.sv
// RGB565 -> 8-bit luma -> binary pixel stage behind the OV7670 capture block, with frame statistics.
// Optional build macro ADAPT_THRESH_EN: threshold for each frame is derived from the previous frame's luma sum.
module pix_gray_bin #(
    parameter int MAX_PIXELS = 60000,
    parameter int BIN_MODE   = 1,
    parameter int SUM_SHIFT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        pix_valid,
    input  logic [15:0] pix_addr,
    input  logic [15:0] pix_data,
    input  logic [7:0]  thresh,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        bin_out,
    output logic        frame_done,
    output logic [15:0] frame_pixels,
    output logic        clip_err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        VS_HIGH = 2'd1,
        ACTIVE  = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam logic [16:0] MAX_P = 17'(MAX_PIXELS);

    if (SUM_SHIFT < 0 || SUM_SHIFT > 23) begin : g_bad_shift
        $error("SUM_SHIFT must lie in 0..23");
    end

    state_t      state, state_nxt;
    logic        vs_s1, vs_s2, vs_s3;
    logic        vs_rise, vs_fall;
    logic [1:0]  drain_cnt;
    logic        accept, clip_hit, frame_start, drain_load, frame_end;
    logic [15:0] pix_cnt;
    logic        clip_flag;
    logic [7:0]  thr_sel;

    // vsync is asynchronous: two synchronizer flops plus one history flop for edge decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1 <= 1'b0;
            vs_s2 <= 1'b0;
            vs_s3 <= 1'b0;
        end else begin
            vs_s1 <= vsync;
            vs_s2 <= vs_s1;
            vs_s3 <= vs_s2;
        end
    end

    assign vs_rise = vs_s2 & ~vs_s3;
    assign vs_fall = ~vs_s2 & vs_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_VS;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_VS: if (vs_s2)           state_nxt = VS_HIGH;
            VS_HIGH: if (vs_fall)         state_nxt = ACTIVE;
            ACTIVE:  if (vs_rise)         state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == 2'd0) state_nxt = VS_HIGH;
            default:                      state_nxt = WAIT_VS;
        endcase
    end

    // pix_valid is a one-cycle strobe with no backpressure: every strobe seen in ACTIVE is
    // consumed in that cycle, either accepted into the pipeline or flagged as clipped.
    always_comb begin
        accept      = (state == ACTIVE) && pix_valid && ({1'b0, pix_addr} < MAX_P);
        clip_hit    = (state == ACTIVE) && pix_valid && ({1'b0, pix_addr} >= MAX_P);
        frame_start = (state == VS_HIGH) && vs_fall;
        drain_load  = (state == ACTIVE) && vs_rise;
        frame_end   = (state == DRAIN) && (drain_cnt == 2'd0);
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 drain_cnt <= 2'd0;
        else if (drain_load)        drain_cnt <= 2'd3;
        else if (state == DRAIN && drain_cnt != 2'd0)
                                    drain_cnt <= drain_cnt - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt      <= 16'd0;
            clip_flag    <= 1'b0;
            frame_done   <= 1'b0;
            frame_pixels <= 16'd0;
            clip_err     <= 1'b0;
        end else begin
            if (frame_start) begin
                pix_cnt   <= 16'd0;
                clip_flag <= 1'b0;
            end else begin
                if (accept && pix_cnt != 16'hFFFF) pix_cnt <= pix_cnt + 16'd1;
                if (clip_hit)                      clip_flag <= 1'b1;
            end
            frame_done <= frame_end;
            if (frame_end) begin
                frame_pixels <= pix_cnt;
                clip_err     <= clip_flag;
            end
        end
    end

    logic        s1_valid, s2_valid;
    logic [15:0] s1_addr, s2_addr;
    logic [7:0]  s1_thr, s2_thr;
    logic [7:0]  s1_r8, s1_g8, s1_b8;
    logic [15:0] s2_pr, s2_pg, s2_pb;
    logic [7:0]  y;
    logic        bin;

    // Weights sum to 256, so the 16-bit sum cannot overflow and its top byte is the luma.
    assign y   = 8'((s2_pr + s2_pg + s2_pb) >> 8);
    assign bin = (y >= s2_thr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_addr  <= 16'd0;
            s1_thr   <= 8'd0;
            s1_r8    <= 8'd0;
            s1_g8    <= 8'd0;
            s1_b8    <= 8'd0;
            s2_valid <= 1'b0;
            s2_addr  <= 16'd0;
            s2_thr   <= 8'd0;
            s2_pr    <= 16'd0;
            s2_pg    <= 16'd0;
            s2_pb    <= 16'd0;
            wr_en    <= 1'b0;
            wr_addr  <= 16'd0;
            wr_data  <= 8'd0;
            bin_out  <= 1'b0;
        end else begin
            s1_valid <= accept;
            s1_addr  <= pix_addr;
            s1_thr   <= thr_sel;
            s1_r8    <= {pix_data[15:11], pix_data[15:13]};
            s1_g8    <= {pix_data[10:5], pix_data[10:9]};
            s1_b8    <= {pix_data[4:0], pix_data[4:2]};
            s2_valid <= s1_valid;
            s2_addr  <= s1_addr;
            s2_thr   <= s1_thr;
            s2_pr    <= 16'(s1_r8) * 16'd77;
            s2_pg    <= 16'(s1_g8) * 16'd150;
            s2_pb    <= 16'(s1_b8) * 16'd29;
            wr_en    <= s2_valid;
            if (s2_valid) begin
                wr_addr <= s2_addr;
                wr_data <= (BIN_MODE != 0) ? {8{bin}} : y;
                bin_out <= bin;
            end
        end
    end

`ifdef ADAPT_THRESH_EN
    logic [23:0] luma_sum;
    logic [23:0] sum_shr;
    logic [7:0]  thr_reg;
    logic        thr_valid;

    assign sum_shr = luma_sum >> SUM_SHIFT;

    // thr_reg only moves at frame end, so a frame never sees its threshold change mid-way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            luma_sum  <= 24'd0;
            thr_reg   <= 8'd0;
            thr_valid <= 1'b0;
        end else begin
            if (frame_start)   luma_sum <= 24'd0;
            else if (s2_valid) luma_sum <= luma_sum + 24'(y);
            if (frame_end) begin
                thr_reg   <= (sum_shr > 24'd255) ? 8'hFF : sum_shr[7:0];
                thr_valid <= 1'b1;
            end
        end
    end

    assign thr_sel = thr_valid ? thr_reg : thresh;
`else
    assign thr_sel = thresh;
`endif

endmodule

// File: tb/tb_pix_gray_bin.sv
// Directed + randomized bench for pix_gray_bin; a second instance with BIN_MODE=0 exposes the luma path.
module tb_pix_gray_bin;

    localparam int MAXP = 60000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_addr = 16'd0;
    logic [15:0] pix_data = 16'd0;
    logic [7:0]  thresh = 8'd0;

    logic        wr_en, bin_out, frame_done, clip_err;
    logic [15:0] wr_addr, frame_pixels;
    logic [7:0]  wr_data;
    logic [1:0]  state_dbg;

    logic        g_wr_en, g_bin_out, g_frame_done, g_clip_err;
    logic [15:0] g_wr_addr, g_frame_pixels;
    logic [7:0]  g_wr_data;
    logic [1:0]  g_state_dbg;

    pix_gray_bin #(.MAX_PIXELS(MAXP), .BIN_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .pix_valid(pix_valid),
        .pix_addr(pix_addr), .pix_data(pix_data), .thresh(thresh),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .bin_out(bin_out),
        .frame_done(frame_done), .frame_pixels(frame_pixels), .clip_err(clip_err),
        .state_dbg(state_dbg)
    );

    pix_gray_bin #(.MAX_PIXELS(MAXP), .BIN_MODE(0)) dut_gray (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .pix_valid(pix_valid),
        .pix_addr(pix_addr), .pix_data(pix_data), .thresh(thresh),
        .wr_en(g_wr_en), .wr_addr(g_wr_addr), .wr_data(g_wr_data), .bin_out(g_bin_out),
        .frame_done(g_frame_done), .frame_pixels(g_frame_pixels), .clip_err(g_clip_err),
        .state_dbg(g_state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    // scoreboard entry: {expected cycle[31:0], addr[15:0], luma[7:0], bin}
    logic [56:0] exp_q[$];

    // reference model state
    bit m_active = 1'b0;
    int m_cnt = 0;
    bit m_clip = 1'b0;
    int m_sum = 0;
    bit m_adv = 1'b0;
    int m_athr = 0;
    int n_done_exp = 0;
    int n_done_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int y_of(input logic [15:0] d);
        int r, g, b, r8, g8, b8;
        r = int'(d[15:11]);
        g = int'(d[10:5]);
        b = int'(d[4:0]);
        r8 = r * 8 + r / 4;
        g8 = g * 4 + g / 16;
        b8 = b * 8 + b / 4;
        return (77 * r8 + 150 * g8 + 29 * b8) / 256;
    endfunction

    // driver tasks
    task automatic drive_pix(input int addr, input logic [15:0] data, input int th);
        int y, thr;
        logic [31:0] ce;
        pix_valid = 1'b1;
        pix_addr  = 16'(addr);
        pix_data  = data;
        thresh    = 8'(th);
        if (m_active) begin
            if (addr < MAXP) begin
                y   = y_of(data);
                thr = m_adv ? m_athr : th;
                ce  = 32'(cyc + 3);
                exp_q.push_back({ce, 16'(addr), 8'(y), (y >= thr)});
                if (m_cnt < 65535) m_cnt++;
                m_sum += y;
            end else begin
                m_clip = 1'b1;
            end
        end
    endtask

    task automatic send_pix(input int addr, input logic [15:0] data, input int th);
        @(negedge clk);
        drive_pix(addr, data, th);
    endtask

    task automatic idle();
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge clk);
        vsync = 1'b0;
        repeat (5) @(negedge clk);
        m_active = 1'b1;
        m_cnt = 0;
        m_clip = 1'b0;
        m_sum = 0;
    endtask

    task automatic raise_vs();
        @(negedge clk);
        vsync = 1'b1;
        m_active = 1'b0;
    endtask

    // Keep strobing across the vsync rise: after the 2-flop sync, the third strobe
    // lands with vs_rise and is still taken; the fourth arrives in DRAIN.
    task automatic end_frame_busy();
        @(negedge clk);
        vsync = 1'b1;
        drive_pix($urandom_range(0, MAXP - 1), 16'($urandom), $urandom_range(0, 255));
        send_pix($urandom_range(0, MAXP - 1), 16'($urandom), $urandom_range(0, 255));
        send_pix($urandom_range(0, MAXP - 1), 16'($urandom), $urandom_range(0, 255));
        m_active = 1'b0;
        send_pix($urandom_range(0, MAXP - 1), 16'($urandom), $urandom_range(0, 255));
        idle();
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        chk("frame_done_seen", 32'(seen), 32'd1);
        if (seen) begin
            n_done_exp++;
            chk("frame_pixels", 32'(frame_pixels), 32'(m_cnt));
            chk("clip_err", 32'(clip_err), 32'(m_clip));
            chk("writes_before_done", 32'(exp_q.size()), 32'd0);
`ifdef ADAPT_THRESH_EN
            m_athr = ((m_sum >> 16) > 255) ? 255 : (m_sum >> 16);
            m_adv = 1'b1;
`endif
            @(negedge clk);
            chk("frame_done_pulse", 32'(frame_done), 32'd0);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [56:0] e;
        bit exp_we;
        if (rst_n) begin
            while (exp_q.size() > 0 && int'(exp_q[0][56:25]) < cyc) begin
                e = exp_q.pop_front();
                chk("wr_missing_cycle", 32'(cyc), e[56:25]);
            end
            exp_we = (exp_q.size() > 0) && (int'(exp_q[0][56:25]) == cyc);
            chk("wr_en", 32'(wr_en), 32'(exp_we));
            chk("gray_wr_en", 32'(g_wr_en), 32'(exp_we));
            if (exp_we) begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e[24:9]));
                chk("bin_out", 32'(bin_out), 32'(e[0]));
                chk("wr_data_bin", 32'(wr_data), e[0] ? 32'hFF : 32'h00);
                chk("wr_data_gray", 32'(g_wr_data), 32'(e[8:1]));
            end
            if (frame_done) n_done_seen++;
        end
    end

    initial begin
        int d183, d182;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_bin_out", 32'(bin_out), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_pixels", 32'(frame_pixels), 32'd0);
        chk("rst_clip_err", 32'(clip_err), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;

        // pixels before the first vsync high, then during VS_HIGH: none written
        repeat (4) send_pix($urandom_range(0, MAXP - 1), 16'($urandom), 0);
        idle();
        @(negedge clk);
        vsync = 1'b1;
        repeat (5) @(negedge clk);
        repeat (4) send_pix($urandom_range(0, MAXP - 1), 16'($urandom), 0);
        idle();

        // frame 1: white, black, red, then random traffic ending across the vsync rise
        start_frame();
        send_pix(5, 16'hFFFF, 128);
        idle();
        repeat (2) @(negedge clk);
        chk("t1_wr_en", 32'(wr_en), 32'd1);
        chk("t1_wr_addr", 32'(wr_addr), 32'd5);
        chk("t1_wr_data", 32'(wr_data), 32'hFF);
        chk("t1_bin_out", 32'(bin_out), 32'd1);
        chk("t1_luma", 32'(g_wr_data), 32'd255);
        send_pix(6, 16'h0000, 80);
        idle();
        send_pix(7, 16'hF800, 80);
        idle();
        repeat (2) @(negedge clk);
        chk("t2_red_addr", 32'(wr_addr), 32'd7);
        chk("t2_red_bin", 32'(bin_out), 32'd0);
        chk("t2_red_data", 32'(wr_data), 32'h00);
        chk("t2_red_luma", 32'(g_wr_data), 32'h4C);
        repeat (40) send_pix($urandom_range(0, MAXP - 1), 16'($urandom), $urandom_range(0, 255));
        idle();
        end_frame_busy();
        wait_done();

        // frame 2: last valid address and first out-of-range address
        start_frame();
        send_pix(MAXP - 1, 16'($urandom), $urandom_range(0, 255));
        send_pix(MAXP, 16'($urandom), $urandom_range(0, 255));
        idle();
        raise_vs();
        wait_done();

        // frame 3: random traffic including clipped addresses, then reset with pixels in flight
        start_frame();
        repeat (30) send_pix($urandom_range(0, 65535), 16'($urandom), $urandom_range(0, 255));
        send_pix(100, 16'($urandom), 0);
        send_pix(101, 16'($urandom), 0);
        @(negedge clk);
        rst_n = 1'b0;
        pix_valid = 1'b0;
        exp_q.delete();
        m_active = 1'b0;
        m_adv = 1'b0;
        #1;
        chk("midrst_wr_en", 32'(wr_en), 32'd0);
        chk("midrst_wr_data", 32'(wr_data), 32'd0);
        chk("midrst_frame_pixels", 32'(frame_pixels), 32'd0);
        chk("midrst_clip_err", 32'(clip_err), 32'd0);
        chk("midrst_state", 32'(state_dbg), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) send_pix($urandom_range(0, MAXP - 1), 16'($urandom), 0);
        idle();
        @(negedge clk);
        vsync = 1'b1;
        repeat (5) @(negedge clk);
        repeat (6) send_pix($urandom_range(0, MAXP - 1), 16'($urandom), 0);
        idle();

        // frame 4: full frame, back to back, every pixel luma 200
        start_frame();
        for (int i = 0; i < MAXP; i++) send_pix(i, 16'hC658, 255);
        idle();
        raise_vs();
        wait_done();

        // frame 5: pixels either side of the adaptive threshold 183
        d183 = -1;
        d182 = -1;
        for (int d = 0; d < 65536; d++) begin
            if (d183 < 0 && y_of(16'(d)) == 183) d183 = d;
            if (d182 < 0 && y_of(16'(d)) == 182) d182 = d;
        end
        start_frame();
        send_pix(1, 16'(d183), 255);
        send_pix(2, 16'(d182), 0);
        idle();
        repeat (3) send_pix($urandom_range(0, MAXP - 1), 16'($urandom), $urandom_range(0, 255));
        idle();
        raise_vs();
        wait_done();

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(n_done_seen), 32'(n_done_exp));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
